regs_arbiter: RTL and testbench

- Two-requester arbiter for the single access port of `register_file` (`regs_if` master side).
- Typical requesters: the host/UART command parser (requester 0) and the internal control FSM that loads and updates timer and configuration registers (requester 1).
- Arbitration is round-robin with an optional lock. The lock makes multi-byte fields (for example the 24-bit `EIR_*_TMR0..2` groups) atomic.
- Every accepted access reaches the register file one cycle after acceptance. Read data returns to the issuing requester.

---
 rtl/regs_arbiter_if.sv | 28 ++
 rtl/regs_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_regs_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_arbiter_if.sv
// Single access port of the register file: one-cycle write/read strobes.
// The file returns read_data on the edge that executes the read strobe.
interface regs_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 6
);
  logic                  write_en;
  logic                  read_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output write_en,
    output read_en,
    output addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/regs_arbiter.sv
// Two-requester round-robin arbiter with optional lock in front of the
// register-file access port; one registered issue stage, read data routed back.
module regs_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_DEPTH   = 64,
  parameter int ADDR_W       = $clog2(DATA_DEPTH),
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req,
  input  logic [1:0]                 req_we,
  input  logic [1:0]                 req_lock,
  input  logic [1:0][ADDR_W-1:0]     req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 gnt,
  output logic [1:0]                 rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       locked,
  output logic                       lock_owner,
  output logic                       lock_err,
  regs_if.master                     if_regs
);

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  localparam logic [7:0]    TIMEOUT_C = 8'(LOCK_TIMEOUT);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DATA_DEPTH);

  lock_state_t state_r, state_nxt_s;
  logic        lock_owner_r, owner_nxt_s;
  logic        prio_r, prio_nxt_s;
  logic [7:0]  idle_cnt_r, idle_nxt_s;
  logic        lock_err_r, lock_err_nxt_s;

  logic [1:0]            gnt_s;
  logic [1:0]            xfer_s;
  logic                  xfer_any_s;
  logic                  xfer_idx_s;
  logic                  sel_we_s;
  logic                  sel_lock_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  in_range_s;

  logic                  write_en_r;
  logic                  read_en_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  idx_r;
  logic                  rd_pend_r;
  logic                  rd_oor_r;
  logic [1:0]            rvalid_r;
  logic                  ret_oor_r;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Grant: lock owner first, otherwise the sole requester or the prio holder.
  always_comb begin
    gnt_s = 2'b00;
    if (state_r == LK_HELD) begin
      gnt_s = lock_owner_r ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign xfer_s      = req & gnt_s;
  assign xfer_any_s  = |xfer_s;
  assign xfer_idx_s  = xfer_s[1];
  assign sel_we_s    = req_we[xfer_idx_s];
  assign sel_lock_s  = req_lock[xfer_idx_s];
  assign sel_addr_s  = req_addr[xfer_idx_s];
  assign sel_wdata_s = req_wdata[xfer_idx_s];
  assign in_range_s  = ({1'b0, sel_addr_s} < DEPTH_C);

  // Lock/priority next state, including the abandoned-lock timeout.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = lock_owner_r;
    prio_nxt_s     = prio_r;
    idle_nxt_s     = idle_cnt_r;
    lock_err_nxt_s = 1'b0;
    case (state_r)
      LK_FREE: begin
        idle_nxt_s = 8'd0;
        if (xfer_any_s && sel_lock_s) begin
          state_nxt_s = LK_HELD;
          owner_nxt_s = xfer_idx_s;
        end else if (xfer_any_s) begin
          prio_nxt_s = ~xfer_idx_s;
        end else begin
          prio_nxt_s = prio_r;
        end
      end
      LK_HELD: begin
        if (xfer_any_s) begin
          idle_nxt_s = 8'd0;
          if (!sel_lock_s) begin
            state_nxt_s = LK_FREE;
            prio_nxt_s  = ~xfer_idx_s;
          end else begin
            owner_nxt_s = xfer_idx_s;
          end
        end else if (!req[lock_owner_r]) begin
          if ((idle_cnt_r + 8'd1) == TIMEOUT_C) begin
            state_nxt_s    = LK_FREE;
            idle_nxt_s     = 8'd0;
            lock_err_nxt_s = 1'b1;
            prio_nxt_s     = ~lock_owner_r;
          end else begin
            idle_nxt_s = idle_cnt_r + 8'd1;
          end
        end else begin
          idle_nxt_s = idle_cnt_r;
        end
      end
      default: begin
        state_nxt_s = LK_FREE;
        idle_nxt_s  = 8'd0;
      end
    endcase
  end

  // Lock/priority state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= LK_FREE;
      lock_owner_r <= 1'b0;
      prio_r       <= 1'b0;
      idle_cnt_r   <= 8'd0;
      lock_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lock_owner_r <= owner_nxt_s;
      prio_r       <= prio_nxt_s;
      idle_cnt_r   <= idle_nxt_s;
      lock_err_r   <= lock_err_nxt_s;
    end
  end

  // Issue stage: out-of-range accesses keep both strobes low but still return a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      idx_r      <= 1'b0;
      rd_pend_r  <= 1'b0;
      rd_oor_r   <= 1'b0;
    end else if (xfer_any_s) begin
      write_en_r <= sel_we_s & in_range_s;
      read_en_r  <= ~sel_we_s & in_range_s;
      addr_r     <= sel_addr_s;
      wdata_r    <= sel_wdata_s;
      idx_r      <= xfer_idx_s;
      rd_pend_r  <= ~sel_we_s;
      rd_oor_r   <= ~in_range_s;
    end else begin
      write_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      rd_pend_r  <= 1'b0;
      rd_oor_r   <= 1'b0;
    end
  end

  // Read return stage, aligned with the register file's registered read_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_r  <= 2'b00;
      ret_oor_r <= 1'b0;
    end else begin
      rvalid_r  <= rd_pend_r ? (idx_r ? 2'b10 : 2'b01) : 2'b00;
      ret_oor_r <= rd_pend_r & rd_oor_r;
    end
  end

  // Shared read bus is zero whenever no return is in progress.
  always_comb begin
    rdata_s = {DATA_WIDTH{1'b0}};
    if ((rvalid_r != 2'b00) && !ret_oor_r) begin
      rdata_s = if_regs.read_data;
    end else begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign gnt                = gnt_s;
  assign rvalid             = rvalid_r;
  assign rdata              = rdata_s;
  assign locked             = (state_r == LK_HELD);
  assign lock_owner         = lock_owner_r;
  assign lock_err           = lock_err_r;
  assign if_regs.write_en   = write_en_r;
  assign if_regs.read_en    = read_en_r;
  assign if_regs.addr       = addr_r;
  assign if_regs.write_data = wdata_r;

endmodule

// File: tb/tb_regs_arbiter.sv
// Scoreboard bench for regs_arbiter: directed transactions push expectations,
// a negedge monitor pops them against port strobes and read returns.
module tb_regs_arbiter;
  localparam int DW = 8;
  localparam int DD = 64;
  localparam int AW = 6;
  // Register-file model map: two read-only registers and the CONN timer group.
  localparam logic [AW-1:0] A_TEST = 6'd62;
  localparam logic [AW-1:0] A_BAUD = 6'd63;
  localparam logic [AW-1:0] A_TMR0 = 6'd32;
  localparam logic [DW-1:0] V_TEST = 8'hAA;
  localparam logic [DW-1:0] V_BAUD = 8'h30;

  typedef struct packed {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [1:0]          req_lock;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DW-1:0]       rdata;
  logic                locked;
  logic                lock_owner;
  logic                lock_err;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  ent_t        wr_q[$];
  ent_t        prd_q[$];
  ent_t        rd_q0[$];
  ent_t        rd_q1[$];
  logic [DW-1:0] shadow [DD];
  logic [DW-1:0] rf_mem [DD];

  regs_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) rif ();

  regs_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .locked(locked), .lock_owner(lock_owner), .lock_err(lock_err),
    .if_regs(rif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model with synchronous read and two read-only locations.
  always @(posedge clk) begin
    if (rif.write_en && rif.addr != A_TEST && rif.addr != A_BAUD) rf_mem[rif.addr] <= rif.write_data;
    if (rif.read_en) rif.read_data <= (rif.addr == A_TEST) ? V_TEST : (rif.addr == A_BAUD) ? V_BAUD : rf_mem[rif.addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: port strobes and read returns against the scoreboard queues.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      check("gnt_onehot", 64'(gnt == 2'b11), 64'd0);
      if (rif.write_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'(rif.write_en), 64'd0);
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_addr", 64'(rif.addr), 64'(e.addr));
          check("wr_data", 64'(rif.write_data), 64'(e.data));
        end
      end
      if (rif.read_en) begin
        if (prd_q.size() == 0) check("rd_unexpected", 64'(rif.read_en), 64'd0);
        else begin
          e = prd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
          check("rd_addr", 64'(rif.addr), 64'(e.addr));
        end
      end
      if (rvalid[0]) begin
        if (rd_q0.size() == 0) check("rvalid0_unexpected", 64'(rvalid), 64'd0);
        else begin
          e = rd_q0.pop_front();
          check("rvalid0_cycle", 64'(cyc), 64'(e.cyc));
          check("rdata0", 64'(rdata), 64'(e.data));
        end
      end
      if (rvalid[1]) begin
        if (rd_q1.size() == 0) check("rvalid1_unexpected", 64'(rvalid), 64'd0);
        else begin
          e = rd_q1.pop_front();
          check("rvalid1_cycle", 64'(cyc), 64'(e.cyc));
          check("rdata1", 64'(rdata), 64'(e.data));
        end
      end
      if (rvalid == 2'b00) check("rdata_idle", 64'(rdata), 64'd0);
    end
  end

  task automatic push_exp(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    e.cyc = cyc + 1; e.addr = a; e.data = d;
    if (we) begin
      wr_q.push_back(e);
      if (a != A_TEST && a != A_BAUD) shadow[a] = d;
    end else begin
      prd_q.push_back(e);
      e.cyc = cyc + 2; e.data = shadow[a];
      if (i == 0) rd_q0.push_back(e); else rd_q1.push_back(e);
    end
  endtask

  // Presents one transaction from requester i and waits (bounded) for its transfer.
  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic lk, output int waited, output logic other);
    waited = 0; other = 1'b0;
    req_we[i] = we; req_lock[i] = lk; req_addr[i] = a; req_wdata[i] = d; req[i] = 1'b1;
    @(negedge clk);
    while (!gnt[i] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!gnt[i]) begin
      check("grant_timeout", 64'(waited), 64'd0);
      req[i] = 1'b0;
    end else begin
      other = gnt[1-i];
      push_exp(i, we, a, d);
      @(posedge clk); #1;
      req[i] = 1'b0;
    end
  endtask

  initial begin
    int w, n0, n1, errs;
    logic o, g1;
    logic [1:0] g;
    int unsigned t0, err_cyc, gnt_cyc;
    req = 2'b00; req_we = 2'b00; req_lock = 2'b00; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < DD; k++) shadow[k] = 8'h00;
    shadow[A_TEST] = V_TEST;
    shadow[A_BAUD] = V_BAUD;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_owner", 64'(lock_owner), 64'd0);
    check("rst_lock_err", 64'(lock_err), 64'd0);
    check("rst_port", 64'({rif.write_en, rif.read_en, rif.addr, rif.write_data}), 64'd0);
    check("rst_gnt_none", 64'(gnt), 64'd0);
    req = 2'b11; #1;
    check("rst_gnt_both", 64'(gnt), 64'(2'b01));
    req = 2'b10; #1;
    check("rst_gnt_r1", 64'(gnt), 64'(2'b10));
    req = 2'b00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Round-robin under continuous contention
    @(posedge clk); #1;
    n0 = 0; n1 = 0;
    req_we = 2'b11; req_lock = 2'b00;
    req_addr[0] = 6'd10; req_wdata[0] = 8'hA0;
    req_addr[1] = 6'd20; req_wdata[1] = 8'hB0;
    req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_gnt", 64'(gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      g = gnt;
      if (g[0]) push_exp(0, 1'b1, req_addr[0], req_wdata[0]);
      else if (g[1]) push_exp(1, 1'b1, req_addr[1], req_wdata[1]);
      @(posedge clk); #1;
      if (g[0]) begin
        n0++; req_addr[0] = req_addr[0] + 6'd1; req_wdata[0] = req_wdata[0] + 8'd1;
      end else if (g[1]) begin
        n1++; req_addr[1] = req_addr[1] + 6'd1; req_wdata[1] = req_wdata[1] + 8'd1;
      end
    end
    req = 2'b00;
    check("rr_count0", 64'(n0), 64'd4);
    check("rr_count1", 64'(n1), 64'd4);

    // Single requester: back-to-back writes then reads of every register
    for (int a = 0; a < DD; a++) begin
      issue(0, 1'b1, AW'(a), DW'(a), 1'b0, w, o);
      check("seq_wr_nowait", 64'(w), 64'd0);
    end
    for (int a = 0; a < DD; a++) begin
      issue(0, 1'b0, AW'(a), 8'h00, 1'b0, w, o);
      check("seq_rd_nowait", 64'(w), 64'd0);
    end
    repeat (4) @(negedge clk);

    // Locked 3-write burst from requester 1 while requester 0 contends
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_lock[0] = 1'b0; req_addr[0] = 6'd48; req_wdata[0] = 8'h55; req[0] = 1'b1;
    issue(1, 1'b1, A_TMR0, 8'h80, 1'b1, w, o);
    check("lk_w0_nowait", 64'(w), 64'd0);
    check("lk_w0_gnt0", 64'(o), 64'd0);
    check("lk_locked", 64'(locked), 64'd1);
    check("lk_owner", 64'(lock_owner), 64'd1);
    issue(1, 1'b1, A_TMR0 + 6'd1, 8'h96, 1'b1, w, o);
    check("lk_w1_nowait", 64'(w), 64'd0);
    check("lk_w1_gnt0", 64'(o), 64'd0);
    issue(1, 1'b1, A_TMR0 + 6'd2, 8'h98, 1'b0, w, o);
    check("lk_w2_nowait", 64'(w), 64'd0);
    check("lk_w2_gnt0", 64'(o), 64'd0);
    check("lk_released", 64'(locked), 64'd0);
    @(negedge clk);
    check("lk_gnt0_rise", 64'(gnt), 64'(2'b01));
    if (gnt[0]) push_exp(0, 1'b1, 6'd48, 8'h55);
    @(posedge clk); #1;
    req[0] = 1'b0;

    // Abandoned lock: timeout release hands the port to requester 1
    @(posedge clk); #1;
    issue(0, 1'b1, 6'd40, 8'h66, 1'b1, w, o);
    t0 = cyc;
    req_we[1] = 1'b0; req_lock[1] = 1'b0; req_addr[1] = A_TMR0; req[1] = 1'b1;
    errs = 0; err_cyc = 0; gnt_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lock_err) begin
        errs++; err_cyc = cyc;
        check("to_locked_fall", 64'(locked), 64'd0);
      end
      g1 = req[1] & gnt[1];
      if (g1) begin
        gnt_cyc = cyc;
        push_exp(1, 1'b0, A_TMR0, 8'h00);
      end
      @(posedge clk); #1;
      if (g1) req[1] = 1'b0;
    end
    req[1] = 1'b0;
    check("to_err_count", 64'(errs), 64'd1);
    check("to_err_cycle", 64'(err_cyc), 64'(t0 + 16));
    check("to_gnt1_cycle", 64'(gnt_cyc), 64'(t0 + 16));
    check("to_unlocked", 64'(locked), 64'd0);

    // Reset while a read is in flight
    @(posedge clk); #1;
    issue(0, 1'b0, 6'd5, 8'h00, 1'b0, w, o);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rd_q0.delete();
    rd_q1.delete();
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    check("mid_rst_lock", 64'({locked, lock_owner, lock_err}), 64'd0);
    check("mid_rst_port", 64'({rif.write_en, rif.read_en, rif.addr, rif.write_data}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_we = 2'b00; req_addr[0] = 6'd1; req_addr[1] = 6'd2; req = 2'b11;
    @(negedge clk);
    check("post_rst_prio", 64'(gnt), 64'(2'b01));
    req = 2'b00;
    repeat (4) @(negedge clk);

    check("end_wr_q", 64'(wr_q.size()), 64'd0);
    check("end_prd_q", 64'(prd_q.size()), 64'd0);
    check("end_rd_q0", 64'(rd_q0.size()), 64'd0);
    check("end_rd_q1", 64'(rd_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
